// File: rtl/layer_engine_adder_ctrl.sv
// Job sequencer for the layer-engine adder: accepts one descriptor,
// issues it as the adder opcode, gates input streams by the job mask
// and pulses job_done once the job's output beat count is reached.
//
// Ports:
//   clk, rst (async, active-low)
//   job_opcode/job_valid/job_ready       descriptor from scheduler
//   opcode/opcode_valid/opcode_accept    opcode offer to adder
//   src_valid/src_ready                  stream source side
//   datain_valid/datain_ready            adder input side (gated)
//   dataout_valid/dataout_ready          adder output (monitored)
//   job_done                             one-cycle completion pulse
//   busy                                 high outside IDLE
module layer_engine_adder_ctrl #(
    parameter int C_NUM_INPUTS   = 3,
    parameter int C_OPCODE_WIDTH = 64,
    parameter int C_CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_OPCODE_WIDTH-1:0] job_opcode,
    input  logic                      job_valid,
    output logic                      job_ready,
    output logic [C_OPCODE_WIDTH-1:0] opcode,
    output logic                      opcode_valid,
    input  logic                      opcode_accept,
    input  logic [C_NUM_INPUTS-1:0]   src_valid,
    output logic [C_NUM_INPUTS-1:0]   src_ready,
    output logic [C_NUM_INPUTS-1:0]   datain_valid,
    input  logic [C_NUM_INPUTS-1:0]   datain_ready,
    input  logic                      dataout_valid,
    input  logic                      dataout_ready,
    output logic                      job_done,
    output logic                      busy
);

    localparam int C_MASK_LO = 16;
    localparam int C_MASK_HI = 16 + C_NUM_INPUTS - 1;
    localparam logic [C_CNT_WIDTH-1:0] C_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [C_OPCODE_WIDTH-1:0] r_opcode;
    logic [C_NUM_INPUTS-1:0]   r_mask;
    logic [C_CNT_WIDTH-1:0]    r_n;
    logic [C_CNT_WIDTH-1:0]    r_cnt;

    logic                      w_idle;
    logic                      w_issue;
    logic                      w_run;
    logic                      w_job_hs;
    logic                      w_op_hs;
    logic                      w_beat;
    logic                      w_last;
    logic [C_CNT_WIDTH-1:0]    w_job_n;

    assign w_idle   = (r_state == S_IDLE);
    assign w_issue  = (r_state == S_ISSUE);
    assign w_run    = (r_state == S_RUN);
    assign w_job_n  = job_opcode[C_CNT_WIDTH-1:0];
    assign w_job_hs = w_idle & job_valid;
    assign w_op_hs  = w_issue & opcode_accept;
    assign w_beat   = w_run & dataout_valid & dataout_ready;
    // Counter holds beats already seen; this beat is the Nth one.
    assign w_last   = w_beat & (r_cnt == r_n - C_ONE);

    // rst term keeps job_ready low while reset is held.
    assign job_ready    = w_idle & rst;
    assign opcode       = r_opcode;
    assign opcode_valid = w_issue;
    assign job_done     = (r_state == S_DONE);
    assign busy         = ~w_idle;
    assign datain_valid = w_run ? (src_valid & r_mask) : '0;
    assign src_ready    = w_run ? (datain_ready & r_mask) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (job_valid) begin
                    w_next = (w_job_n != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (opcode_accept) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_opcode <= '0;
            r_mask   <= '0;
            r_n      <= '0;
        end else if (w_job_hs) begin
            r_opcode <= job_opcode;
            r_mask   <= job_opcode[C_MASK_HI:C_MASK_LO];
            r_n      <= w_job_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_op_hs) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule

// File: doc/layer_engine_adder_ctrl.md
# layer_engine_adder_ctrl

Job sequencer for the layer-engine adder. It takes one job descriptor at a time from the layer scheduler, issues the descriptor as the adder's opcode, and gates the per-input stream handshakes so that only the inputs the job enables reach the adder. It counts accepted output beats and pulses completion when the job's beat count has been produced. It sits between the input stream sources / layer scheduler and the adder instance.

## Interface
- C_NUM_INPUTS, 3, number of adder input streams
- C_OPCODE_WIDTH, 64, job/opcode word width; must be ≥ 16 + C_NUM_INPUTS
- C_CNT_WIDTH, 16, beat counter width; fixed equal to the job count field width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- job_opcode  in  C_OPCODE_WIDTH  descriptor; [15:0] = output beat count N, [16+C_NUM_INPUTS-1:16] = input enable mask, remaining bits opaque
- job_valid  in  1  descriptor valid
- job_ready  out  1  descriptor accepted when job_valid & job_ready
- opcode  out  C_OPCODE_WIDTH  registered copy of the accepted descriptor, to adder
- opcode_valid  out  1  opcode offer to adder
- opcode_accept  in  1  adder takes opcode when opcode_valid & opcode_accept
- src_valid  in  C_NUM_INPUTS  per-input valid from stream sources
- src_ready  out  C_NUM_INPUTS  per-input ready to stream sources
- datain_valid  out  C_NUM_INPUTS  gated valid to adder
- datain_ready  in  C_NUM_INPUTS  ready from adder
- dataout_valid  in  1  adder output valid (monitored)
- dataout_ready  in  1  adder output ready from consumer (monitored)
- job_done  out  1  one-cycle completion pulse
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, RUN, DONE.
- IDLE: job_ready=1. On job_valid: register the descriptor into opcode, mask, and N.
  - N≠0 → ISSUE.
  - N=0 → DONE; no opcode is issued.
- ISSUE: opcode_valid=1, opcode held stable. On opcode_accept → RUN and clear the beat counter.
- RUN:
  - datain_valid = src_valid & mask (combinational).
  - src_ready = datain_ready & mask (combinational).
  - Count one beat for each cycle with dataout_valid & dataout_ready.
  - When the counted beat is number N (counter == N−1 and handshake) → DONE.
- DONE: job_done=1 for exactly one cycle, then → IDLE.
- Outside RUN: datain_valid=0 and src_ready=0 on all inputs. Masked-off inputs are also held at 0 during RUN.
- A mask of all zeros is legal. The controller waits in RUN until the adder produces N beats; it never times out.
- Beats on dataout after DONE are not counted and do not affect state.
- The counter is C_CNT_WIDTH bits. N=0xFFFF needs 65535 beats; the counter never wraps within a job.
- The opcode register holds its last value in IDLE; opcode is don't-care while opcode_valid=0.

## Timing
- Reset (rst=0), asynchronous and effective immediately:
  - state=IDLE, counter=0, opcode=0, mask=0.
  - opcode_valid=0, job_done=0, busy=0.
  - datain_valid=0, src_ready=0.
  - job_ready rises with IDLE, once rst is deasserted.
- Reset mid-job aborts the job. No job_done is produced, and the adder's own reset is the system's responsibility.
- Job accept at cycle T:
  - opcode_valid=1 from T+1.
  - If opcode_accept is high at T+1, gating opens at T+2.
- Last output handshake at cycle L: job_done=1 at L+1; job_ready=1 at L+2.
- Back-to-back jobs: the next job is accepted no earlier than L+2.
- opcode_valid, once asserted, stays high until accepted; opcode is unchanged while waiting.
- job_ready is registered-state decoded: high only in IDLE, with no combinational path from job_valid.
- Gating paths (src_valid→datain_valid, datain_ready→src_ready) are combinational, with zero added latency.

## Test plan
- Reset/idle: hold rst=0 with random inputs → all outputs 0. Release → job_ready=1, busy=0, job_done=0.
- Basic job: descriptor N=4, mask=3'b011; adder accepts opcode immediately; 4 output handshakes → opcode_valid for 1 cycle, input 2 never sees valid/ready, job_done exactly 1 cycle after the 4th handshake, job_ready one cycle later.
- Opcode backpressure: opcode_accept low for 5 cycles → opcode_valid held with opcode constant, src_ready=0 throughout, RUN entered the cycle after accept.
- Output stalls: dataout_valid=1 with dataout_ready toggling, N=3 → only cycles with both high are counted; done after the 3rd such cycle.
- N=0 job → no opcode_valid, job_done pulses at T+1, job_ready at T+2. Follow with an N=1 job, which completes normally.
- Reset mid-RUN after 2 of 8 beats → outputs clear immediately, no job_done. The next job with N=2 completes after exactly 2 beats (counter was cleared).
